// File: rtl/alu_result_commit_pkg.sv
// Shared CPU definitions: datapath widths, 5-bit opcodes, result-commit classes.
// Pure declarations, no logic, so there is no latency or backpressure.
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  localparam logic [4:0] OP_LDW  = 5'b00000;
  localparam logic [4:0] OP_LDWI = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [2:0] {
    ALU_WB  = 3'd0,
    HILO    = 3'd1,
    MOVE    = 3'd2,
    ADDR    = 3'd3,
    BRANCH  = 3'd4,
    NONE    = 3'd5,
    ILLEGAL = 3'd6
  } res_class_e;

endpackage

// File: rtl/alu_result_commit_if.sv
// ALU result bus: valid/ready handshake carrying opcode, 2*DATA_W result and destination.
// The producer holds every field stable while res_valid is high and res_ready is low.
interface alu_result_commit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic                  res_valid;
  logic                  res_ready;
  logic [4:0]            opcode;
  logic [2*DATA_W-1:0]   rc;
  logic [REG_AW-1:0]     dest;

  modport master (output res_valid, output opcode, output rc, output dest, input res_ready);
  modport slave  (input res_valid, input opcode, input rc, input dest, output res_ready);
endinterface

// File: rtl/alu_result_commit_decode.sv
// Opcode to result-commit class, purely combinational (zero latency, no backpressure).
// Shared with the control unit, so unassigned codes map to ILLEGAL here, not at the caller.
module wb_class_decode (
  input  logic [4:0]           opcode_i,
  output cpu_defs::res_class_e cls_o
);
  import cpu_defs::*;

  always_comb begin
    cls_o = ILLEGAL;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT:      cls_o = ALU_WB;
      OP_MUL, OP_DIV:                                cls_o = HILO;
      OP_MFHI, OP_MFLO:                              cls_o = MOVE;
      OP_LDW, OP_LDWI, OP_STW:                       cls_o = ADDR;
      OP_BR:                                         cls_o = BRANCH;
      OP_JR, OP_JAL, OP_IN, OP_OUT, OP_NOP, OP_HALT: cls_o = NONE;
      default:                                       cls_o = ILLEGAL;
    endcase
  end
endmodule

// File: rtl/alu_result_commit.sv
// Latches one ALU result into Z, commits it to RF/HI-LO/MAR/PC two cycles after accept.
// One result in flight: res_ready only in IDLE, so a new accept is possible the cycle after commit.
module alu_result_commit #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int REG_AW = cpu_defs::REG_AW
) (
  input  logic                clk,
  input  logic                clear,
  alu_result_commit_if.slave  res,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                mar_load,
  output logic [DATA_W-1:0]   mar_data,
  output logic                pc_load,
  output logic [DATA_W-1:0]   pc_data,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out,
  output logic                illegal
);
  import cpu_defs::*;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ZLATCH = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] zhi_q, zlo_q, hi_q, lo_q;
  logic [4:0]        op_q;
  logic [REG_AW-1:0] dest_q;
  res_class_e        cls_w, cls_q;
  logic              rf_we_q, mar_load_q, pc_load_q, illegal_q;
  logic [REG_AW-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_wdata_q, mar_data_q, pc_data_q;
  logic              accept;

  assign res.res_ready = (state_q == ST_IDLE);
  assign accept        = res.res_valid && (state_q == ST_IDLE);

  wb_class_decode u_decode (
    .opcode_i (op_q),
    .cls_o    (cls_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ZLATCH;
      ST_ZLATCH: state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      zhi_q      <= '0;
      zlo_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      op_q       <= '0;
      dest_q     <= '0;
      cls_q      <= NONE;
      rf_we_q    <= 1'b0;
      mar_load_q <= 1'b0;
      pc_load_q  <= 1'b0;
      illegal_q  <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      mar_data_q <= '0;
      pc_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= 1'b0;
      mar_load_q <= 1'b0;
      pc_load_q  <= 1'b0;
      illegal_q  <= 1'b0;
      if (accept) begin
        zhi_q  <= res.rc[2*DATA_W-1:DATA_W];
        zlo_q  <= res.rc[DATA_W-1:0];
        op_q   <= res.opcode;
        dest_q <= res.dest;
      end
      // Strobes and data are registered on entry to COMMIT; data holds while idle.
      if (state_q == ST_ZLATCH) begin
        cls_q <= cls_w;
        case (cls_w)
          ALU_WB: begin
            rf_we_q    <= 1'b1;
            rf_addr_q  <= dest_q;
            rf_wdata_q <= zlo_q;
          end
          MOVE: begin
            rf_we_q    <= 1'b1;
            rf_addr_q  <= dest_q;
            rf_wdata_q <= (op_q == OP_MFHI) ? hi_q : lo_q;
          end
          ADDR: begin
            mar_load_q <= 1'b1;
            mar_data_q <= zlo_q;
          end
          BRANCH: begin
            pc_load_q <= 1'b1;
            pc_data_q <= zlo_q;
          end
          ILLEGAL: illegal_q <= 1'b1;
          default: ;
        endcase
      end
      if ((state_q == ST_COMMIT) && (cls_q == HILO)) begin
        hi_q <= zhi_q;
        lo_q <= zlo_q;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;
  assign mar_load = mar_load_q;
  assign mar_data = mar_data_q;
  assign pc_load  = pc_load_q;
  assign pc_data  = pc_data_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign illegal  = illegal_q;
endmodule

// File: tb/tb_alu_result_commit.sv
// Directed bench for alu_result_commit: hand-computed expectations, sampled on the falling edge.
module tb_alu_result_commit;
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  alu_result_commit_if #(.DATA_W(32), .REG_AW(4)) res_if ();

  logic        rf_we, mar_load, pc_load, illegal;
  logic [3:0]  rf_addr;
  logic [31:0] rf_wdata, mar_data, pc_data, hi_out, lo_out;

  alu_result_commit #(.DATA_W(32), .REG_AW(4)) dut (
    .clk      (clk),
    .clear    (clear),
    .res      (res_if),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .mar_load (mar_load),
    .mar_data (mar_data),
    .pc_load  (pc_load),
    .pc_data  (pc_data),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .illegal  (illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Values seen during the COMMIT cycle of the last transaction.
  logic        c_we, c_mar, c_pc, c_ill;
  logic [3:0]  c_addr;
  logic [31:0] c_wd, c_md, c_pd, c_hi, c_lo;

  // Called just after a falling edge with the block idle; returns just after a falling edge, idle again.
  task automatic txn(input logic [4:0] op, input logic [63:0] rc, input logic [3:0] dst);
    chk("rdy_idle", res_if.res_ready, 1);
    res_if.res_valid = 1'b1;
    res_if.opcode    = op;
    res_if.rc        = rc;
    res_if.dest      = dst;
    @(posedge clk);
    @(negedge clk);
    res_if.res_valid = 1'b0;
    chk("rdy_zlatch", res_if.res_ready, 0);
    chk("zl_quiet", {rf_we, mar_load, pc_load, illegal}, 0);
    @(negedge clk);
    chk("rdy_commit", res_if.res_ready, 0);
    c_we = rf_we;  c_mar = mar_load; c_pc = pc_load; c_ill = illegal;
    c_addr = rf_addr; c_wd = rf_wdata; c_md = mar_data; c_pd = pc_data;
    c_hi = hi_out; c_lo = lo_out;
    @(negedge clk);
  endtask

  initial begin
    clear            = 1'b1;
    res_if.res_valid = 1'b0;
    res_if.opcode    = '0;
    res_if.rc        = '0;
    res_if.dest      = '0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    chk("rst_ready", res_if.res_ready, 1);
    chk("rst_strobes", {rf_we, mar_load, pc_load, illegal}, 0);
    chk("rst_data", {rf_addr, rf_wdata, mar_data, pc_data}, 0);
    chk("rst_hilo", {hi_out, lo_out}, 0);

    // add: writes zlo to rf[3]
    txn(5'b00011, 64'h0000_0000_0000_0007, 4'd3);
    chk("add_we", c_we, 1);
    chk("add_addr", c_addr, 3);
    chk("add_wdata", c_wd, 32'h7);
    chk("add_other", {c_mar, c_pc, c_ill}, 0);
    chk("add_we_drop", rf_we, 0);

    // mul: HI/LO update after commit, no GPR write, RF data holds
    txn(5'b01110, 64'hDEAD_BEEF_1234_5678, 4'd9);
    chk("mul_we", c_we, 0);
    chk("mul_hold_wd", c_wd, 32'h7);
    chk("mul_hi_commit", c_hi, 32'h0);
    chk("mul_hi", hi_out, 32'hDEAD_BEEF);
    chk("mul_lo", lo_out, 32'h1234_5678);

    txn(5'b10111, 64'h5555_5555_5555_5555, 4'd5);
    chk("mfhi_we", c_we, 1);
    chk("mfhi_addr", c_addr, 5);
    chk("mfhi_wdata", c_wd, 32'hDEAD_BEEF);

    txn(5'b11000, 64'h0, 4'd6);
    chk("mflo_addr", c_addr, 6);
    chk("mflo_wdata", c_wd, 32'h1234_5678);

    // ldw: only zlo goes to MAR
    txn(5'b00000, 64'hFFFF_FFFF_0000_0080, 4'd1);
    chk("ldw_mar", c_mar, 1);
    chk("ldw_data", c_md, 32'h80);
    chk("ldw_other", {c_we, c_pc, c_ill}, 0);

    txn(5'b10010, 64'h0000_0001_0000_0024, 4'd2);
    chk("br_pc", c_pc, 1);
    chk("br_data", c_pd, 32'h24);
    chk("br_other", {c_we, c_mar, c_ill}, 0);
    chk("br_mar_hold", c_md, 32'h80);

    txn(5'b11111, 64'h0, 4'd0);
    chk("ill_pulse", c_ill, 1);
    chk("ill_other", {c_we, c_mar, c_pc}, 0);
    chk("ill_drop", illegal, 0);

    txn(5'b11001, 64'h0, 4'd0);
    chk("nop_quiet", {c_we, c_mar, c_pc, c_ill}, 0);

    // valid held high with changing data: first value commits, next accept waits for IDLE
    res_if.res_valid = 1'b1;
    res_if.opcode    = 5'b00011;
    res_if.rc        = 64'h11;
    res_if.dest      = 4'd2;
    @(posedge clk);
    @(negedge clk);
    res_if.rc   = 64'h22;
    res_if.dest = 4'd7;
    chk("hold_rdy_zl", res_if.res_ready, 0);
    @(negedge clk);
    chk("hold_we", rf_we, 1);
    chk("hold_first", {rf_addr, rf_wdata}, {4'd2, 32'h11});
    res_if.rc = 64'h33;
    @(negedge clk);
    chk("hold_rdy_idle", res_if.res_ready, 1);
    chk("hold_idle_we", rf_we, 0);
    res_if.rc   = 64'h44;
    res_if.dest = 4'd4;
    @(posedge clk);
    @(negedge clk);
    res_if.res_valid = 1'b0;
    chk("hold_rdy_zl2", res_if.res_ready, 0);
    @(negedge clk);
    chk("hold_second", {rf_we, rf_addr, rf_wdata}, {1'b1, 4'd4, 32'h44});
    @(negedge clk);

    // clear during ZLATCH drops the in-flight mul and zeroes HI/LO
    res_if.res_valid = 1'b1;
    res_if.opcode    = 5'b01110;
    res_if.rc        = 64'h0000_0001_0000_0002;
    res_if.dest      = 4'd1;
    @(posedge clk);
    @(negedge clk);
    res_if.res_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_strobes", {rf_we, mar_load, pc_load, illegal}, 0);
    chk("clr_hilo", {hi_out, lo_out}, 0);
    chk("clr_ready", res_if.res_ready, 1);
    @(negedge clk);
    chk("clr_strobes2", {rf_we, mar_load, pc_load, illegal}, 0);
    chk("clr_hilo2", {hi_out, lo_out}, 0);
    chk("clr_ready2", res_if.res_ready, 1);
    chk("clr_data", {rf_wdata, mar_data, pc_data}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
